// File: rtl/mode7_pkg.sv
// Shared definitions for the sign-magnitude sequential multiplier:
// default word geometry, magnitude upper bound and FSM state encoding.
package mode7_pkg;

    localparam int SIZE_DEF = 24;
    localparam int FRAC_DEF = 8;

    // Largest representable magnitude at the default word size: 2^(SIZE-1)-1.
    localparam logic [SIZE_DEF-2:0] UPPER_BOUND = {(SIZE_DEF-1){1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } sm_state_e;

endpackage

// File: rtl/sm_sat_clip.sv
// Product normalisation for sm_mul_seq: drops the FRAC fractional bits of
// the raw magnitude product, clips to the largest representable magnitude,
// and clears the sign of a zero result so negative zero never leaves the block.
// Build option: SM_MUL_ROUND_EN adds half an LSB before the shift (round half
// up on magnitude); without it the fractional bits are truncated. Clipping
// always happens after rounding.
module sm_sat_clip
    import mode7_pkg::*;
#(
    parameter int              SIZE  = SIZE_DEF,
    parameter int              FRAC  = FRAC_DEF,
    parameter logic [SIZE-2:0] UPPER = UPPER_BOUND
) (
    input  logic [2*(SIZE-1)-1:0] acc_i,
    input  logic                  sign_i,
    output logic [SIZE-1:0]       data_o,
    output logic                  sat_o
);

    localparam int M  = SIZE - 1;
    localparam int AW = 2 * M;

    // One spare bit so the rounding increment can never wrap.
    logic [AW:0]  rounded;
    logic [AW:0]  shifted;
    logic [M-1:0] mag;

`ifdef SM_MUL_ROUND_EN
    assign rounded = {1'b0, acc_i} + ((AW+1)'(1) << (FRAC - 1));
`else
    assign rounded = {1'b0, acc_i};
`endif

    assign shifted = rounded >> FRAC;

    // Saturate the shifted magnitude and suppress the sign of a zero result.
    always_comb begin
        sat_o  = 1'b0;
        mag    = shifted[M-1:0];
        data_o = '0;
        if (shifted > {{(AW+1-M){1'b0}}, UPPER}) begin
            sat_o = 1'b1;
            mag   = '1;
        end
        data_o = {(mag != '0) & sign_i, mag};
    end

endmodule

// File: rtl/sm_mul_seq.sv
// Sign-magnitude fixed-point multiplier, one shift-add step per cycle.
// Operands are taken in IDLE, SIZE-1 iterations run in BUSY, and the
// normalised product is held in DONE until the downstream stage takes it.
// Build option: SM_MUL_ROUND_EN selects round-half-up instead of truncation
// (applied inside sm_sat_clip).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for operands, in_ready high
// BUSY  | shift-add iterations running, counter counts down to zero
// DONE  | product held on out_data/out_sat, out_valid high until taken
module sm_mul_seq
    import mode7_pkg::*;
#(
    parameter int SIZE = SIZE_DEF,
    parameter int FRAC = FRAC_DEF
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [SIZE-1:0] a,
    input  logic [SIZE-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SIZE-1:0] out_data,
    output logic            out_sat
);

    localparam int M  = SIZE - 1;
    localparam int AW = 2 * M;
    localparam int CW = (M > 1) ? $clog2(M) : 1;

    sm_state_e       state_q,    state_d;
    logic [CW-1:0]   cnt_q,      cnt_d;
    logic [AW-1:0]   acc_q,      acc_d;
    logic [AW-1:0]   mcand_q,    mcand_d;
    logic [M-1:0]    mplier_q,   mplier_d;
    logic            sign_q,     sign_d;
    logic [SIZE-1:0] out_data_q, out_data_d;
    logic            out_sat_q,  out_sat_d;

    logic [AW-1:0]   acc_step;
    logic [SIZE-1:0] clip_data;
    logic            clip_sat;

    // Accumulator value after the current iteration; on the last BUSY cycle
    // this is the complete product, so it feeds the normaliser directly.
    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    sm_sat_clip #(
        .SIZE (SIZE),
        .FRAC (FRAC)
    ) u_clip (
        .acc_i  (acc_step),
        .sign_i (sign_q),
        .data_o (clip_data),
        .sat_o  (clip_sat)
    );

    // State, datapath and output registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            mcand_q    <= '0;
            mplier_q   <= '0;
            sign_q     <= 1'b0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            mcand_q    <= mcand_d;
            mplier_q   <= mplier_d;
            sign_q     <= sign_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

    // Next-state, datapath updates and handshake outputs.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        mcand_d    = mcand_q;
        mplier_d   = mplier_q;
        sign_d     = sign_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;

        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    mcand_d  = {{M{1'b0}}, a[M-1:0]};
                    mplier_d = b[M-1:0];
                    acc_d    = '0;
                    sign_d   = a[SIZE-1] ^ b[SIZE-1];
                    cnt_d    = CW'(M - 1);
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                acc_d    = acc_step;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                if (cnt_q == '0) begin
                    out_data_d = clip_data;
                    out_sat_d  = clip_sat;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign out_data = out_data_q;
    assign out_sat  = out_sat_q;

endmodule

// File: tb/tb_sm_mul_seq.sv
// Directed and random checks for sm_mul_seq with a queue scoreboard:
// expected products are pushed when operands are offered and popped when
// the block presents a result.
module tb_sm_mul_seq;

    localparam int SIZE = 24;
    localparam int FRAC = 8;
    localparam int LAT  = SIZE - 1;

    typedef struct packed {
        logic [SIZE-1:0] data;
        logic            sat;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [SIZE-1:0] a = '0;
    logic [SIZE-1:0] b = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SIZE-1:0] out_data;
    logic            out_sat;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];

    sm_mul_seq #(.SIZE(SIZE), .FRAC(FRAC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [SIZE-1:0] d, input logic s);
        exp_t e;
        e.data = d;
        e.sat  = s;
        return e;
    endfunction

    // Reference: full-precision product, optional half-LSB round, clip, zero sign.
    function automatic exp_t model(input logic [SIZE-1:0] x, input logic [SIZE-1:0] y);
        logic [63:0] p;
        logic [63:0] r;
        exp_t        e;
        p = 64'(x[SIZE-2:0]) * 64'(y[SIZE-2:0]);
`ifdef SM_MUL_ROUND_EN
        p = p + (64'd1 << (FRAC - 1));
`endif
        r = p >> FRAC;
        if (r > 64'h7F_FFFF) begin
            e.sat            = 1'b1;
            e.data[SIZE-2:0] = '1;
        end else begin
            e.sat            = 1'b0;
            e.data[SIZE-2:0] = r[SIZE-2:0];
        end
        e.data[SIZE-1] = (e.data[SIZE-2:0] != '0) && (x[SIZE-1] ^ y[SIZE-1]);
        return e;
    endfunction

    task automatic send(input logic [SIZE-1:0] aa, input logic [SIZE-1:0] bb, input exp_t e);
        @(negedge clk);
        a        = aa;
        b        = bb;
        in_valid = 1'b1;
        check("in_ready_before_accept", 32'(in_ready), 32'd1);
        sb_q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = $urandom;
        b        = $urandom;
    endtask

    task automatic wait_done();
        int lat;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            #1;
            lat++;
            if (out_valid) break;
        end
        check("latency", 32'(lat), 32'(LAT));
    endtask

    task automatic collect();
        exp_t e;
        if (sb_q.size() == 0) begin
            check("scoreboard_underflow", 32'(sb_q.size()), 32'd1);
            e = '0;
        end else begin
            e = sb_q.pop_front();
        end
        check("out_valid", 32'(out_valid), 32'd1);
        check("out_data", 32'(out_data), 32'(e.data));
        check("out_sat", 32'(out_sat), 32'(e.sat));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("out_valid_after_handoff", 32'(out_valid), 32'd0);
        check("in_ready_after_handoff", 32'(in_ready), 32'd1);
    endtask

    task automatic run(input logic [SIZE-1:0] aa, input logic [SIZE-1:0] bb, input exp_t e);
        send(aa, bb, e);
        wait_done();
        collect();
    endtask

    initial begin
        exp_t        e;
        logic [31:0] ra;
        logic [31:0] rb;
        logic [SIZE-1:0] aa;
        logic [SIZE-1:0] bb;
        logic        seen;

        // Reset values while rst_n is held low.
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed products with literal expectations.
        run(24'h000200, 24'h000300, mk(24'h000600, 1'b0));
        run(24'h800180, 24'h000200, mk(24'h800300, 1'b0));
        run(24'h800000, 24'h000100, mk(24'h000000, 1'b0));
        run(24'h7FFFFF, 24'h7FFFFF, mk(24'h7FFFFF, 1'b1));
        run(24'hFFFFFF, 24'h7FFFFF, mk(24'hFFFFFF, 1'b1));
`ifdef SM_MUL_ROUND_EN
        run(24'h000001, 24'h000080, mk(24'h000001, 1'b0));
`else
        run(24'h000001, 24'h000080, mk(24'h000000, 1'b0));
`endif

        // Random operands against the reference model, mixed magnitudes.
        for (int i = 0; i < 6; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 2 == 0) begin
                aa = {ra[31], 11'd0, ra[11:0]};
                bb = {rb[31], 10'd0, rb[12:0]};
            end else begin
                aa = ra[SIZE-1:0];
                bb = rb[SIZE-1:0];
            end
            run(aa, bb, model(aa, bb));
        end

        // Downstream stalls 10 cycles in DONE while new operands are offered.
        send(24'h000400, 24'h000400, mk(24'h001000, 1'b0));
        wait_done();
        e = sb_q[0];
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            a        = 24'h000123;
            b        = 24'h000456;
            check("stall_out_valid", 32'(out_valid), 32'd1);
            check("stall_out_data", 32'(out_data), 32'(e.data));
            check("stall_out_sat", 32'(out_sat), 32'(e.sat));
            check("stall_in_ready", 32'(in_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        collect();

        // No acceptance on the handoff edge; acceptance on the next one.
        send(24'h000500, 24'h800200, mk(24'h800A00, 1'b0));
        wait_done();
        e = sb_q.pop_front();
        check("handoff_out_data", 32'(out_data), 32'(e.data));
        in_valid  = 1'b1;
        a         = 24'h000300;
        b         = 24'h000300;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check("handoff_no_accept", 32'(in_ready), 32'd1);
        check("handoff_out_valid", 32'(out_valid), 32'd0);
        sb_q.push_back(mk(24'h000900, 1'b0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("accept_after_handoff", 32'(in_ready), 32'd0);
        wait_done();
        collect();

        // Reset mid-multiply: no output, then a fresh pair works.
        send(24'h000300, 24'h000500, mk(24'h000F00, 1'b0));
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        void'(sb_q.pop_back());
        #1;
        check("abort_out_valid", 32'(out_valid), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        check("abort_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1'b1;
        end
        check("abort_no_output", 32'(seen), 32'd0);
        run(24'h800280, 24'h000400, mk(24'h800A00, 1'b0));

        check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
